// File: rtl/eth_latency_pkg.sv
// Shared types for the probe latency tracker: record status codes, log record,
// probe slot layout and the latency saturation helper.
package eth_latency_pkg;

    // Upper bounds on the configurable widths; records and slots are sized to these.
    localparam int unsigned SEQ_MAX_W  = 64;
    localparam int unsigned TIME_MAX_W = 64;
    localparam int unsigned LAT_MAX_W  = 64;

    typedef enum logic [1:0] {
        ST_OK        = 2'd0,
        ST_TIMEOUT   = 2'd1,
        ST_UNMATCHED = 2'd2
    } status_e;

    typedef struct packed {
        status_e                status;
        logic [LAT_MAX_W-1:0]   latency;
        logic [SEQ_MAX_W-1:0]   seq;
    } log_rec_t;

    typedef struct packed {
        logic                   busy;
        logic [SEQ_MAX_W-1:0]   seq;
        logic [TIME_MAX_W-1:0]  ts;
    } slot_t;

    // Clamp a tick count to lat_w bits, returning all-ones when it does not fit.
    function automatic logic [LAT_MAX_W-1:0] saturate(input logic [TIME_MAX_W-1:0] diff,
                                                      input int unsigned lat_w);
        logic [LAT_MAX_W-1:0] mask;
        mask = (lat_w >= LAT_MAX_W) ? '1 : ((LAT_MAX_W'(1) << lat_w) - LAT_MAX_W'(1));
        return ((diff & ~mask) != '0) ? mask : diff;
    endfunction

endpackage

// File: rtl/eth_latency_log_fifo.sv
// Synchronous first-word-fall-through FIFO for log records; full/empty from occupancy.
module eth_latency_log_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en_i,
    input  logic [W-1:0] wr_data_i,
    input  logic         rd_en_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [W-1:0] rd_data_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push, pop;

    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign push      = wr_en_i & ~full_o;
    assign pop       = rd_en_i & ~empty_o;
    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

    assign wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    assign rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    assign count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);

    // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; stale words are never visible because rd_data_o is gated by empty_o.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/eth_latency_tracker.sv
// Multi-slot probe round-trip latency tracker with timeout scanner and log FIFO.
// Optional latency min/max/sum statistics build with ETH_LATENCY_STATS_EN.
module eth_latency_tracker
    import eth_latency_pkg::*;
#(
    parameter int C_NUM_SLOTS  = 8,
    parameter int C_SEQ_WIDTH  = 32,
    parameter int C_TIME_WIDTH = 64,
    parameter int C_LAT_WIDTH  = 32,
    parameter int C_LOG_DEPTH  = 4
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [C_TIME_WIDTH-1:0]                  current_time,
    input  logic                                     time_running,
    input  logic                                     enable,
    input  logic [C_LAT_WIDTH-1:0]                   timeout,
    input  logic                                     tx_valid,
    output logic                                     tx_ready,
    input  logic [C_SEQ_WIDTH-1:0]                   tx_seq,
    input  logic                                     rx_valid,
    input  logic [C_SEQ_WIDTH-1:0]                   rx_seq,
    output logic                                     m_axis_log_tvalid,
    input  logic                                     m_axis_log_tready,
    output logic [2+C_LAT_WIDTH+C_SEQ_WIDTH-1:0]     m_axis_log_tdata,
    output logic [31:0]                              stat_ok,
    output logic [31:0]                              stat_timeout,
    output logic [31:0]                              stat_unmatched,
    output logic [31:0]                              stat_overflow,
    output logic [C_LAT_WIDTH-1:0]                   stat_lat_min,
    output logic [C_LAT_WIDTH-1:0]                   stat_lat_max,
    output logic [63:0]                              stat_lat_sum
);

    localparam int IDX_W = $clog2(C_NUM_SLOTS);
    localparam int REC_W = 2 + C_LAT_WIDTH + C_SEQ_WIDTH;

    slot_t                   slots_q [C_NUM_SLOTS];
    slot_t                   slots_d [C_NUM_SLOTS];
    slot_t                   rx_slot, scan_slot;
    logic [IDX_W-1:0]        tx_idx, rx_idx, scan_ptr_q, scan_ptr_d;
    logic [C_TIME_WIDTH-1:0] rx_diff, scan_diff;
    logic [LAT_MAX_W-1:0]    rx_sat, scan_sat;
    logic                    tx_fire, rx_match, scan_stall, scan_hit;
    logic                    fifo_full, fifo_empty;
    log_rec_t                wr_rec;
    logic [REC_W-1:0]        wr_data;
    logic [31:0]             stat_ok_q, stat_timeout_q, stat_unmatched_q, stat_overflow_q;
    logic                    unused_bits;

    assign tx_idx    = tx_seq[IDX_W-1:0];
    assign rx_idx    = rx_seq[IDX_W-1:0];
    assign rx_slot   = slots_q[rx_idx];
    assign scan_slot = slots_q[scan_ptr_q];

    assign tx_ready = enable & ~rst & ~slots_q[tx_idx].busy;
    assign tx_fire  = tx_valid & tx_ready;

    // Elapsed ticks wrap with the timer, so plain modular subtraction is correct.
    assign rx_diff   = current_time - rx_slot.ts[C_TIME_WIDTH-1:0];
    assign scan_diff = current_time - scan_slot.ts[C_TIME_WIDTH-1:0];
    assign rx_sat    = saturate(TIME_MAX_W'(rx_diff), C_LAT_WIDTH);
    assign scan_sat  = saturate(TIME_MAX_W'(scan_diff), C_LAT_WIDTH);

    assign rx_match   = rx_valid & rx_slot.busy & (rx_slot.seq[C_SEQ_WIDTH-1:0] == rx_seq);
    assign scan_stall = rx_valid | fifo_full | ~time_running | (timeout == '0) | ~enable;
    assign scan_hit   = ~scan_stall & scan_slot.busy & (scan_diff > C_TIME_WIDTH'(timeout));

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        wr_rec = '0;
        if (rx_valid) begin
            wr_rec.status  = rx_match ? ST_OK : ST_UNMATCHED;
            wr_rec.latency = rx_match ? rx_sat : '0;
            wr_rec.seq     = SEQ_MAX_W'(rx_seq);
        end else if (scan_hit) begin
            wr_rec.status  = ST_TIMEOUT;
            wr_rec.latency = scan_sat;
            wr_rec.seq     = scan_slot.seq;
        end
    end

    assign wr_data = {wr_rec.status, wr_rec.latency[C_LAT_WIDTH-1:0], wr_rec.seq[C_SEQ_WIDTH-1:0]};

    // rx, tx and scanner never touch the same slot in one cycle: tx needs a free
    // slot, rx and the scanner need a busy one, and the scanner stalls on rx.
    always_comb begin
        slots_d    = slots_q;
        scan_ptr_d = scan_ptr_q;
        if (!enable) begin
            for (int i = 0; i < C_NUM_SLOTS; i++) slots_d[i] = '0;
            scan_ptr_d = '0;
        end else begin
            if (tx_fire)
                slots_d[tx_idx] = '{busy: 1'b1, seq: SEQ_MAX_W'(tx_seq),
                                    ts: TIME_MAX_W'(current_time)};
            if (rx_match)    slots_d[rx_idx].busy     = 1'b0;
            if (scan_hit)    slots_d[scan_ptr_q].busy = 1'b0;
            if (!scan_stall) scan_ptr_d = scan_ptr_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < C_NUM_SLOTS; i++) slots_q[i] <= '0;
            scan_ptr_q       <= '0;
            stat_ok_q        <= '0;
            stat_timeout_q   <= '0;
            stat_unmatched_q <= '0;
            stat_overflow_q  <= '0;
        end else begin
            slots_q          <= slots_d;
            scan_ptr_q       <= scan_ptr_d;
            stat_ok_q        <= stat_ok_q + 32'(rx_match);
            stat_timeout_q   <= stat_timeout_q + 32'(scan_hit);
            stat_unmatched_q <= stat_unmatched_q + 32'(rx_valid & ~rx_match);
            stat_overflow_q  <= stat_overflow_q + 32'(rx_valid & fifo_full);
        end
    end

    eth_latency_log_fifo #(
        .W     (REC_W),
        .DEPTH (C_LOG_DEPTH)
    ) u_log_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (rx_valid | scan_hit),
        .wr_data_i (wr_data),
        .rd_en_i   (m_axis_log_tready),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .rd_data_o (m_axis_log_tdata)
    );

    assign m_axis_log_tvalid = ~fifo_empty;
    assign stat_ok           = stat_ok_q;
    assign stat_timeout      = stat_timeout_q;
    assign stat_unmatched    = stat_unmatched_q;
    assign stat_overflow     = stat_overflow_q;

`ifdef ETH_LATENCY_STATS_EN
    logic [C_LAT_WIDTH-1:0] rx_lat, lat_min_q, lat_max_q;
    logic [63:0]            lat_sum_q;
    logic [64:0]            sum_ext;

    assign rx_lat  = rx_sat[C_LAT_WIDTH-1:0];
    assign sum_ext = {1'b0, lat_sum_q} + 65'(rx_lat);

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_min_q <= '1;
            lat_max_q <= '0;
            lat_sum_q <= '0;
        end else if (rx_match) begin
            if (rx_lat < lat_min_q) lat_min_q <= rx_lat;
            if (rx_lat > lat_max_q) lat_max_q <= rx_lat;
            lat_sum_q <= sum_ext[64] ? '1 : sum_ext[63:0];
        end
    end

    assign stat_lat_min = lat_min_q;
    assign stat_lat_max = lat_max_q;
    assign stat_lat_sum = lat_sum_q;
`else
    assign stat_lat_min = '1;
    assign stat_lat_max = '0;
    assign stat_lat_sum = '0;
`endif

    // Records and slots are sized for the widest configuration; fold the spare bits here.
    assign unused_bits = ^{rx_slot, scan_slot, rx_sat, scan_sat, wr_rec};

endmodule

// File: tb/tb_eth_latency_tracker.sv
// Directed self-checking bench for eth_latency_tracker (default build and a 16-bit latency build).
module tb_eth_latency_tracker;

    logic        clk = 1'b0;
    logic        rst, time_running, enable, tx_valid, rx_valid, tready;
    logic [63:0] current_time;
    logic [31:0] timeout, tx_seq, rx_seq;

    logic        tx_ready, tvalid;
    logic [65:0] tdata;
    logic [31:0] stat_ok, stat_timeout, stat_unmatched, stat_overflow;
    logic [31:0] lat_min, lat_max;
    logic [63:0] lat_sum;

    logic        tx_ready16, tvalid16;
    logic [49:0] tdata16;
    logic [31:0] ok16, to16, um16, ov16;
    logic [15:0] min16, max16;
    logic [63:0] sum16;

    int tests_run    = 0;
    int tests_failed = 0;

`ifdef ETH_LATENCY_STATS_EN
    localparam logic [31:0] EXP_MIN = 32'd250;
    localparam logic [31:0] EXP_MAX = 32'd250;
    localparam logic [63:0] EXP_SUM = 64'd250;
`else
    localparam logic [31:0] EXP_MIN = 32'hFFFF_FFFF;
    localparam logic [31:0] EXP_MAX = 32'd0;
    localparam logic [63:0] EXP_SUM = 64'd0;
`endif

    always #5 clk = ~clk;

    eth_latency_tracker u_dut (
        .clk(clk), .rst(rst), .current_time(current_time), .time_running(time_running),
        .enable(enable), .timeout(timeout), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_seq(tx_seq), .rx_valid(rx_valid), .rx_seq(rx_seq),
        .m_axis_log_tvalid(tvalid), .m_axis_log_tready(tready), .m_axis_log_tdata(tdata),
        .stat_ok(stat_ok), .stat_timeout(stat_timeout), .stat_unmatched(stat_unmatched),
        .stat_overflow(stat_overflow), .stat_lat_min(lat_min), .stat_lat_max(lat_max),
        .stat_lat_sum(lat_sum)
    );

    eth_latency_tracker #(.C_LAT_WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .current_time(current_time), .time_running(time_running),
        .enable(enable), .timeout(timeout[15:0]), .tx_valid(tx_valid), .tx_ready(tx_ready16),
        .tx_seq(tx_seq), .rx_valid(rx_valid), .rx_seq(rx_seq),
        .m_axis_log_tvalid(tvalid16), .m_axis_log_tready(tready), .m_axis_log_tdata(tdata16),
        .stat_ok(ok16), .stat_timeout(to16), .stat_unmatched(um16),
        .stat_overflow(ov16), .stat_lat_min(min16), .stat_lat_max(max16),
        .stat_lat_sum(sum16)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; tx_valid = 1'b0; rx_valid = 1'b0; tready = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic send_tx(input logic [31:0] s, input logic [63:0] t);
        tx_seq = s; current_time = t; tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
    endtask

    task automatic send_rx(input logic [31:0] s, input logic [63:0] t);
        rx_seq = s; current_time = t; rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic pop();
        tready = 1'b1;
        step();
        tready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; tx_seq = '0;
        step(); step();
        #1;
        tests_run++;
        if (tx_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_tx_ready: got %b want 0", tx_ready); end
        tests_run++;
        if (tvalid !== 1'b0 || tdata !== '0) begin
            tests_failed++; $display("FAIL reset_log: tvalid %b tdata %h want 0/0", tvalid, tdata);
        end
        tests_run++;
        if ({stat_ok, stat_timeout, stat_unmatched, stat_overflow} !== '0) begin
            tests_failed++;
            $display("FAIL reset_counters: %0d %0d %0d %0d want all 0", stat_ok, stat_timeout, stat_unmatched, stat_overflow);
        end
        tests_run++;
        if (lat_min !== 32'hFFFF_FFFF || lat_max !== '0 || lat_sum !== '0) begin
            tests_failed++; $display("FAIL reset_lat_stats: min %h max %h sum %h", lat_min, lat_max, lat_sum);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (tx_ready !== 1'b1) begin tests_failed++; $display("FAIL post_reset_tx_ready: got %b want 1", tx_ready); end
    endtask

    task automatic test_match();
        logic [65:0] exp_rec;
        do_reset();
        send_tx(32'd5, 64'd1000);
        #1;
        tests_run++;
        if (tx_ready !== 1'b0) begin tests_failed++; $display("FAIL match_slot_busy: tx_ready %b want 0", tx_ready); end
        send_rx(32'd5, 64'd1250);
        exp_rec = {2'd0, 32'd250, 32'd5};
        tests_run++;
        if (tvalid !== 1'b1 || tdata !== exp_rec) begin
            tests_failed++; $display("FAIL match_rec: tvalid %b tdata %h want 1 %h", tvalid, tdata, exp_rec);
        end
        tests_run++;
        if (stat_ok !== 32'd1) begin tests_failed++; $display("FAIL match_stat_ok: got %0d want 1", stat_ok); end
        tests_run++;
        if (lat_min !== EXP_MIN || lat_max !== EXP_MAX || lat_sum !== EXP_SUM) begin
            tests_failed++;
            $display("FAIL match_lat_stats: min %0d max %0d sum %0d want %0d %0d %0d", lat_min, lat_max, lat_sum, EXP_MIN, EXP_MAX, EXP_SUM);
        end
        pop();
        tests_run++;
        if (tvalid !== 1'b0 || tx_ready !== 1'b1) begin
            tests_failed++; $display("FAIL match_drain: tvalid %b tx_ready %b want 0 1", tvalid, tx_ready);
        end
    endtask

    task automatic test_unmatched();
        logic [65:0] exp_rec;
        do_reset();
        send_rx(32'd7, 64'd500);
        exp_rec = {2'd2, 32'd0, 32'd7};
        tests_run++;
        if (tvalid !== 1'b1 || tdata !== exp_rec) begin
            tests_failed++; $display("FAIL unmatched_rec: tvalid %b tdata %h want 1 %h", tvalid, tdata, exp_rec);
        end
        tests_run++;
        if (stat_unmatched !== 32'd1 || stat_ok !== 32'd0) begin
            tests_failed++; $display("FAIL unmatched_stats: unmatched %0d ok %0d want 1 0", stat_unmatched, stat_ok);
        end
        pop();
    endtask

    task automatic test_timeout();
        logic        found;
        logic [31:0] lat;
        logic [65:0] exp_rec;
        do_reset();
        timeout = 32'd100;
        send_tx(32'd3, 64'd0);
        found = 1'b0;
        for (int i = 1; i <= 200 && !found; i++) begin
            current_time = 64'(i);
            step();
            if (tvalid) found = 1'b1;
        end
        tests_run++;
        if (!found) begin
            tests_failed++; $display("FAIL timeout_seen: no record within 200 cycles, want one");
        end
        lat = tdata[63:32];
        tests_run++;
        if (tdata[65:64] !== 2'd1 || tdata[31:0] !== 32'd3) begin
            tests_failed++; $display("FAIL timeout_rec: status %0d seq %0d want 1 3", tdata[65:64], tdata[31:0]);
        end
        tests_run++;
        if (lat < 32'd101 || lat > 32'd109) begin
            tests_failed++; $display("FAIL timeout_latency: got %0d want 101..109", lat);
        end
        tests_run++;
        if (stat_timeout !== 32'd1) begin tests_failed++; $display("FAIL timeout_stat: got %0d want 1", stat_timeout); end
        pop();
        timeout = 32'd0;
        send_rx(32'd3, 64'd500);
        exp_rec = {2'd2, 32'd0, 32'd3};
        tests_run++;
        if (tdata !== exp_rec || stat_unmatched !== 32'd1) begin
            tests_failed++; $display("FAIL late_reply: tdata %h unmatched %0d want %h 1", tdata, stat_unmatched, exp_rec);
        end
        pop();
    endtask

    task automatic test_slot_collision();
        logic [65:0] exp_rec;
        do_reset();
        send_tx(32'd2, 64'd2000);
        tx_seq = 32'd10; tx_valid = 1'b1; current_time = 64'd2010;
        #1;
        tests_run++;
        if (tx_ready !== 1'b0) begin tests_failed++; $display("FAIL collide_blocked: tx_ready %b want 0", tx_ready); end
        step(); step();
        tests_run++;
        if (tx_ready !== 1'b0) begin tests_failed++; $display("FAIL collide_held: tx_ready %b want 0", tx_ready); end
        rx_seq = 32'd2; rx_valid = 1'b1; current_time = 64'd2040;
        step();
        rx_valid = 1'b0; current_time = 64'd2050;
        #1;
        tests_run++;
        if (tx_ready !== 1'b1) begin tests_failed++; $display("FAIL collide_freed: tx_ready %b want 1", tx_ready); end
        exp_rec = {2'd0, 32'd40, 32'd2};
        tests_run++;
        if (tdata !== exp_rec) begin tests_failed++; $display("FAIL collide_rec2: tdata %h want %h", tdata, exp_rec); end
        step();
        tx_valid = 1'b0;
        #1;
        tests_run++;
        if (tx_ready !== 1'b0) begin tests_failed++; $display("FAIL collide_accepted: tx_ready %b want 0", tx_ready); end
        pop();
        send_rx(32'd10, 64'd2100);
        exp_rec = {2'd0, 32'd50, 32'd10};
        tests_run++;
        if (tdata !== exp_rec || stat_ok !== 32'd2) begin
            tests_failed++; $display("FAIL collide_rec10: tdata %h ok %0d want %h 2", tdata, stat_ok, exp_rec);
        end
        pop();
    endtask

    task automatic test_back_to_back();
        logic [65:0] exp_rec, first;
        do_reset();
        for (int i = 0; i < 6; i++) send_tx(32'(16 + i), 64'(3000 + i));
        for (int i = 0; i < 6; i++) send_rx(32'(16 + i), 64'd3100);
        tests_run++;
        if (stat_ok !== 32'd6 || stat_overflow !== 32'd2) begin
            tests_failed++; $display("FAIL b2b_stats: ok %0d overflow %0d want 6 2", stat_ok, stat_overflow);
        end
        first = tdata;
        step();
        tests_run++;
        if (tvalid !== 1'b1 || tdata !== first) begin
            tests_failed++; $display("FAIL b2b_hold: tvalid %b tdata %h want 1 %h", tvalid, tdata, first);
        end
        for (int i = 0; i < 6; i++) begin
            tx_seq = 32'(16 + i);
            #1;
            tests_run++;
            if (tx_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_freed seq %0d: tx_ready %b want 1", 16 + i, tx_ready); end
        end
        for (int i = 0; i < 4; i++) begin
            exp_rec = {2'd0, 32'(100 - i), 32'(16 + i)};
            tests_run++;
            if (tvalid !== 1'b1 || tdata !== exp_rec) begin
                tests_failed++; $display("FAIL b2b_rec%0d: tvalid %b tdata %h want 1 %h", i, tvalid, tdata, exp_rec);
            end
            pop();
        end
        tests_run++;
        if (tvalid !== 1'b0) begin tests_failed++; $display("FAIL b2b_empty: tvalid %b want 0", tvalid); end
    endtask

    task automatic test_saturation();
        logic [65:0] exp_rec;
        logic [49:0] exp_rec16;
        do_reset();
        send_tx(32'd9, 64'd0);
        send_rx(32'd9, 64'd70000);
        exp_rec   = {2'd0, 32'd70000, 32'd9};
        exp_rec16 = {2'd0, 16'hFFFF, 32'd9};
        tests_run++;
        if (tdata !== exp_rec) begin tests_failed++; $display("FAIL sat_wide: tdata %h want %h", tdata, exp_rec); end
        tests_run++;
        if (tvalid16 !== 1'b1 || tdata16 !== exp_rec16) begin
            tests_failed++; $display("FAIL sat_16: tvalid %b tdata %h want 1 %h", tvalid16, tdata16, exp_rec16);
        end
        pop();
    endtask

    task automatic test_rst_midop();
        do_reset();
        send_rx(32'd30, 64'd10);
        send_tx(32'd1, 64'd20);
        send_tx(32'd2, 64'd21);
        send_tx(32'd3, 64'd22);
        tests_run++;
        if (tvalid !== 1'b1) begin tests_failed++; $display("FAIL rst_pre: tvalid %b want 1", tvalid); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        tests_run++;
        if (tvalid !== 1'b0 || tdata !== '0 || stat_unmatched !== 32'd0) begin
            tests_failed++; $display("FAIL rst_cleared: tvalid %b tdata %h unmatched %0d want 0 0 0", tvalid, tdata, stat_unmatched);
        end
        for (int s = 1; s <= 3; s++) begin
            tx_seq = 32'(s);
            #1;
            tests_run++;
            if (tx_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_slot%0d: tx_ready %b want 1", s, tx_ready); end
        end
        step(); step();
        tests_run++;
        if (tvalid !== 1'b0) begin tests_failed++; $display("FAIL rst_no_records: tvalid %b want 0", tvalid); end
    endtask

    task automatic test_enable_clear();
        do_reset();
        send_rx(32'd40, 64'd50);
        send_tx(32'd4, 64'd100);
        enable = 1'b0;
        step();
        enable = 1'b1;
        tx_seq = 32'd4;
        #1;
        tests_run++;
        if (tx_ready !== 1'b1) begin tests_failed++; $display("FAIL enable_clear_slot: tx_ready %b want 1", tx_ready); end
        tests_run++;
        if (tvalid !== 1'b1 || stat_unmatched !== 32'd1) begin
            tests_failed++; $display("FAIL enable_keep: tvalid %b unmatched %0d want 1 1", tvalid, stat_unmatched);
        end
        send_rx(32'd4, 64'd200);
        tests_run++;
        if (stat_unmatched !== 32'd2 || stat_ok !== 32'd0) begin
            tests_failed++; $display("FAIL enable_reply: unmatched %0d ok %0d want 2 0", stat_unmatched, stat_ok);
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; time_running = 1'b1; timeout = '0;
        tx_valid = 1'b0; tx_seq = '0; rx_valid = 1'b0; rx_seq = '0;
        tready = 1'b0; current_time = '0;
        test_reset();
        test_match();
        test_unmatched();
        test_timeout();
        test_slot_collision();
        test_back_to_back();
        test_saturation();
        test_rst_midop();
        test_enable_clear();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
